// File: rtl/spi_frame_slave_pkg.sv
// Shared constants and FSM state type for the SPI frame slave.
package spi_pkg;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ERR_CNT_W  = 8;
  localparam logic [FRAME_BITS-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, WAIT_CS} spi_state_t;
endpackage

// File: rtl/spi_frame_slave_if.sv
// Pin and controller-side bundle of the SPI frame slave; frame_err/err_cnt exist
// only when SPI_FRAME_ERR_EN is defined.
interface spi_frame_slave_if;
  logic                            sclk;
  logic                            cs_n;
  logic                            mosi;
  logic                            miso;
  logic [spi_pkg::FRAME_BITS-1:0]  spi_data_tx;
  logic [spi_pkg::FRAME_BITS-1:0]  spi_data_rx;
  logic                            readBusy;
  logic                            writeBusy;
`ifdef SPI_FRAME_ERR_EN
  logic                            frame_err;
  logic [spi_pkg::ERR_CNT_W-1:0]   err_cnt;
`endif

  modport slave (
    input  sclk, cs_n, mosi, spi_data_tx,
`ifdef SPI_FRAME_ERR_EN
    output frame_err, err_cnt,
`endif
    output miso, spi_data_rx, readBusy, writeBusy
  );

  modport master (
    output sclk, cs_n, mosi, spi_data_tx,
`ifdef SPI_FRAME_ERR_EN
    input  frame_err, err_cnt,
`endif
    input  miso, spi_data_rx, readBusy, writeBusy
  );
endinterface

// File: rtl/spi_frame_slave_sync.sv
// Multi-flop synchroniser with a trailing flop for single-cycle edge pulses.
module spi_sync #(
  parameter int unsigned STAGES   = 2,
  parameter logic        IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic level_o,
  output logic rise_c_o,
  output logic fall_c_o
);
  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{IDLE_LVL}};
      dly_q  <= IDLE_LVL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level_o  = sync_q[STAGES-1];
  assign rise_c_o = sync_q[STAGES-1] & ~dly_q;
  assign fall_c_o = ~sync_q[STAGES-1] & dly_q;
endmodule

// File: rtl/spi_frame_slave.sv
// Oversampling SPI mode-0 frame slave; SPI_FRAME_ERR_EN adds abort flag/counter.
module spi_frame_slave #(
  parameter int unsigned FRAME_BITS  = spi_pkg::FRAME_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  spi_frame_slave_if.slave    bus
);
  import spi_pkg::*;

  localparam int unsigned CNT_W    = $clog2(FRAME_BITS + 1);
  localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [SETTLE_W-1:0] SETTLED  = SETTLE_W'(SYNC_STAGES + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;
  logic unused_sclk_lvl;

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .din_i(bus.sclk),
    .level_o(sclk_lvl), .rise_c_o(sclk_rise), .fall_c_o(sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .din_i(bus.cs_n),
    .level_o(cs_lvl), .rise_c_o(cs_rise), .fall_c_o(cs_fall)
  );

  assign unused_sclk_lvl = sclk_lvl;

  always_ff @(posedge clk) begin
    if (reset) mosi_sync_q <= '0;
    else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_t            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  miso_q, miso_d;
  logic                  rbusy_q, rbusy_d;
  logic                  wbusy_q, wbusy_d;
  logic                  abort_q, abort_d;
  logic                  armed_q, armed_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
`ifdef SPI_FRAME_ERR_EN
  logic                  frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      rbusy_q     <= 1'b0;
      wbusy_q     <= 1'b0;
      abort_q     <= 1'b0;
      armed_q     <= 1'b0;
      settle_q    <= '0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      miso_q      <= miso_d;
      rbusy_q     <= rbusy_d;
      wbusy_q     <= wbusy_d;
      abort_q     <= abort_d;
      armed_q     <= armed_d;
      settle_q    <= settle_d;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    miso_d      = miso_q;
    rbusy_d     = rbusy_q;
    wbusy_d     = wbusy_q;
    abort_d     = abort_q;
`ifdef SPI_FRAME_ERR_EN
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
`endif
    // Frames only start once cs_n has been seen high after the sync chain flushes,
    // so a frame interrupted by reset is ignored to its end.
    settle_d = (settle_q == SETTLED) ? settle_q : settle_q + SETTLE_W'(1);
    armed_d  = armed_q | ((settle_q == SETTLED) & cs_lvl);

    case (state_q)
      IDLE: begin
        if (armed_q && cs_fall) begin
          tx_shift_d = bus.spi_data_tx;
          miso_d     = bus.spi_data_tx[FRAME_BITS-1];
          wbusy_d    = 1'b1;
          rbusy_d    = 1'b1;
          bit_cnt_d  = '0;
          abort_d    = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end
        if (sclk_fall) begin
          tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
          miso_d     = tx_shift_q[FRAME_BITS-2];
        end
        // A final sclk edge coincident with cs rising still completes the frame.
        if (sclk_rise && (bit_cnt_q == LAST_BIT)) begin
          state_d = COMMIT;
          abort_d = 1'b0;
        end else if (cs_rise) begin
          state_d = COMMIT;
          abort_d = 1'b1;
`ifdef SPI_FRAME_ERR_EN
          frame_err_d = 1'b1;
          err_cnt_d   = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
`endif
        end
      end
      COMMIT: begin
        rx_data_d = abort_q ? FRAME_BITS'(NOP_WORD) : rx_shift_q;
        state_d   = WAIT_CS;
      end
      WAIT_CS: begin
        rbusy_d = 1'b0;
        if (cs_lvl) begin
          wbusy_d = 1'b0;
          miso_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.miso        = miso_q;
  assign bus.spi_data_rx = rx_data_q;
  assign bus.readBusy    = rbusy_q;
  assign bus.writeBusy   = wbusy_q;
`ifdef SPI_FRAME_ERR_EN
  assign bus.frame_err   = frame_err_q;
  assign bus.err_cnt     = err_cnt_q;
`endif
endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave; covers the SPI_FRAME_ERR_EN outputs when defined.
module tb_spi_frame_slave;
  localparam int HALF = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_frame_slave_if bus();

  spi_frame_slave #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Event monitor, sampled on the inactive edge.
  int cyc = 0, rx_upd_cyc = 0, rb_fall_cyc = 0, wb_fall_cyc = 0, rb_falls = 0, fe_high = 0;
  logic [15:0] prev_rx = 16'h0000;
  logic prev_rb = 1'b0, prev_wb = 1'b0;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    prev_rx <= bus.spi_data_rx;
    prev_rb <= bus.readBusy;
    prev_wb <= bus.writeBusy;
    if (bus.spi_data_rx !== prev_rx) rx_upd_cyc <= cyc;
    if (prev_rb === 1'b1 && bus.readBusy === 1'b0) begin
      rb_fall_cyc <= cyc;
      rb_falls    <= rb_falls + 1;
    end
    if (prev_wb === 1'b1 && bus.writeBusy === 1'b0) wb_fall_cyc <= cyc;
`ifdef SPI_FRAME_ERR_EN
    if (bus.frame_err === 1'b1) fe_high <= fe_high + 1;
`endif
  end

  logic [15:0] snap_rx;
  logic        snap_rb, snap_wb, snap_miso;
  logic [7:0]  snap_err;
  int          rb_mark;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [15:0] mo, input int nbits, input int chg_at,
                      input logic [15:0] new_tx, input int rst_at, output logic [15:0] mi);
    mi = 16'h0000;
    bus.cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_at) bus.spi_data_tx = new_tx;
      if (i == rst_at) begin
        reset = 1'b1;
        clks(1);
        snap_rx   = bus.spi_data_rx;
        snap_rb   = bus.readBusy;
        snap_wb   = bus.writeBusy;
        snap_miso = bus.miso;
        snap_err  = 8'h00;
`ifdef SPI_FRAME_ERR_EN
        snap_err  = bus.err_cnt;
`endif
        reset = 1'b0;
        clks(1);
        rb_mark = rb_falls;
      end
      bus.mosi = (i < 16) ? mo[15-i] : 1'b0;
      clks(HALF);
      if (i < 16) mi[15-i] = bus.miso;
      bus.sclk = 1'b1;
      clks(HALF);
      bus.sclk = 1'b0;
    end
    bus.mosi = 1'b0;
    clks(HALF);
  endtask

  task automatic cs_release();
    bus.cs_n = 1'b1;
    clks(12);
  endtask

  task automatic test_reset();
    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0; bus.spi_data_tx = 16'h0000;
    reset = 1'b1;
    clks(3);
    reset = 1'b0;
    clks(20);
    checks++; if (bus.spi_data_rx !== 16'h0000) begin errors++; $display("FAIL reset_rx: got %h expected 0000", bus.spi_data_rx); end
    checks++; if (bus.readBusy !== 1'b0) begin errors++; $display("FAIL reset_readBusy: got %b expected 0", bus.readBusy); end
    checks++; if (bus.writeBusy !== 1'b0) begin errors++; $display("FAIL reset_writeBusy: got %b expected 0", bus.writeBusy); end
    checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", bus.miso); end
`ifdef SPI_FRAME_ERR_EN
    checks++; if (bus.err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt: got %h expected 00", bus.err_cnt); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
`endif
  endtask

  task automatic test_basic();
    logic [15:0] mi;
    int n0;
    bus.spi_data_tx = 16'h0123;
    n0 = rb_falls;
    xfer(16'h2ABC, 16, -1, 16'h0000, -1, mi);
    checks++; if (mi !== 16'h0123) begin errors++; $display("FAIL basic_miso: got %h expected 0123", mi); end
    checks++; if (bus.spi_data_rx !== 16'h2ABC) begin errors++; $display("FAIL basic_rx: got %h expected 2abc", bus.spi_data_rx); end
    checks++; if (bus.readBusy !== 1'b0) begin errors++; $display("FAIL basic_readBusy: got %b expected 0", bus.readBusy); end
    checks++; if (bus.writeBusy !== 1'b1) begin errors++; $display("FAIL basic_writeBusy_held: got %b expected 1", bus.writeBusy); end
    checks++; if (rb_fall_cyc !== rx_upd_cyc + 1) begin errors++; $display("FAIL basic_strobe_timing: fall at %0d expected %0d", rb_fall_cyc, rx_upd_cyc + 1); end
    cs_release();
    checks++; if (bus.writeBusy !== 1'b0) begin errors++; $display("FAIL basic_writeBusy_drop: got %b expected 0", bus.writeBusy); end
    checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL basic_miso_idle: got %b expected 0", bus.miso); end
    checks++; if (rb_falls - n0 !== 1) begin errors++; $display("FAIL basic_strobe_count: got %0d expected 1", rb_falls - n0); end
    checks++; if (!(wb_fall_cyc > rb_fall_cyc)) begin errors++; $display("FAIL basic_wb_after_rb: wb %0d rb %0d expected wb later", wb_fall_cyc, rb_fall_cyc); end
  endtask

  task automatic test_abort();
    logic [15:0] mi;
    int n0, f0;
    bus.spi_data_tx = 16'hC3A5;
    n0 = rb_falls;
    f0 = fe_high;
    xfer(16'hB7E1, 7, -1, 16'h0000, -1, mi);
    checks++; if (bus.readBusy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid: got %b expected 1", bus.readBusy); end
    checks++; if ((mi & 16'hFE00) !== 16'hC200) begin errors++; $display("FAIL abort_miso: got %h expected c200", mi & 16'hFE00); end
    cs_release();
    checks++; if (bus.spi_data_rx !== 16'h0000) begin errors++; $display("FAIL abort_rx: got %h expected 0000", bus.spi_data_rx); end
    checks++; if (bus.readBusy !== 1'b0 || bus.writeBusy !== 1'b0) begin errors++; $display("FAIL abort_busy_end: got %b%b expected 00", bus.readBusy, bus.writeBusy); end
    checks++; if (rb_fall_cyc !== wb_fall_cyc) begin errors++; $display("FAIL abort_same_cycle: rb %0d wb %0d expected equal", rb_fall_cyc, wb_fall_cyc); end
    checks++; if (rb_falls - n0 !== 1) begin errors++; $display("FAIL abort_strobe_count: got %0d expected 1", rb_falls - n0); end
`ifdef SPI_FRAME_ERR_EN
    checks++; if (fe_high - f0 !== 1) begin errors++; $display("FAIL abort_frame_err: high %0d cycles expected 1", fe_high - f0); end
    checks++; if (bus.err_cnt !== 8'h01) begin errors++; $display("FAIL abort_err_cnt: got %h expected 01", bus.err_cnt); end
`else
    checks++; if (fe_high - f0 !== 0) begin errors++; $display("FAIL abort_no_err: got %0d expected 0", fe_high - f0); end
`endif
  endtask

  task automatic test_tx_change();
    logic [15:0] mi;
    bus.spi_data_tx = 16'h00F0;
    xfer(16'h1234, 16, 5, 16'hFFFF, -1, mi);
    cs_release();
    checks++; if (mi !== 16'h00F0) begin errors++; $display("FAIL txchg_miso: got %h expected 00f0", mi); end
    checks++; if (bus.spi_data_rx !== 16'h1234) begin errors++; $display("FAIL txchg_rx: got %h expected 1234", bus.spi_data_rx); end
  endtask

  task automatic test_overrun();
    logic [15:0] mi;
    int n0;
    bus.spi_data_tx = 16'h8001;
    n0 = rb_falls;
    xfer(16'h3055, 20, -1, 16'h0000, -1, mi);
    cs_release();
    checks++; if (bus.spi_data_rx !== 16'h3055) begin errors++; $display("FAIL overrun_rx: got %h expected 3055", bus.spi_data_rx); end
    checks++; if (rb_falls - n0 !== 1) begin errors++; $display("FAIL overrun_strobe_count: got %0d expected 1", rb_falls - n0); end
    checks++; if (mi !== 16'h8001) begin errors++; $display("FAIL overrun_miso: got %h expected 8001", mi); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] mi;
    bus.spi_data_tx = 16'hA5A5;
    xfer(16'h4321, 16, -1, 16'h0000, 9, mi);
    cs_release();
    checks++; if (snap_rx !== 16'h0000) begin errors++; $display("FAIL rstmid_rx: got %h expected 0000", snap_rx); end
    checks++; if (snap_rb !== 1'b0 || snap_wb !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b%b expected 00", snap_rb, snap_wb); end
    checks++; if (snap_miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b expected 0", snap_miso); end
    checks++; if (snap_err !== 8'h00) begin errors++; $display("FAIL rstmid_err_cnt: got %h expected 00", snap_err); end
    checks++; if (rb_falls - rb_mark !== 0) begin errors++; $display("FAIL rstmid_no_strobe: got %0d expected 0", rb_falls - rb_mark); end
    checks++; if (bus.spi_data_rx !== 16'h0000) begin errors++; $display("FAIL rstmid_rx_end: got %h expected 0000", bus.spi_data_rx); end
    checks++; if (bus.readBusy !== 1'b0 || bus.writeBusy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_end: got %b%b expected 00", bus.readBusy, bus.writeBusy); end
  endtask

  task automatic test_after_reset();
    logic [15:0] mi;
    bus.spi_data_tx = 16'h0F0F;
    xfer(16'h5A5A, 16, -1, 16'h0000, -1, mi);
    cs_release();
    checks++; if (bus.spi_data_rx !== 16'h5A5A) begin errors++; $display("FAIL post_rst_rx: got %h expected 5a5a", bus.spi_data_rx); end
    checks++; if (mi !== 16'h0F0F) begin errors++; $display("FAIL post_rst_miso: got %h expected 0f0f", mi); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_tx_change();
    test_overrun();
    test_reset_mid();
    test_after_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
